// File: rtl/fsm_3_mealy_pkg.sv
// Shared types for the three-state Mealy controller.
// The encodings are the observable p_state/n_state values; 2'b11 is unused and must never persist.
package fsm_3_mealy_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        S0   = 2'b01,
        S1   = 2'b10
    } state_t;

endpackage : fsm_3_mealy_pkg

// File: rtl/fsm_3_mealy_ctrl_if.sv
// Data/observation bundle of the Mealy controller.
// The master drives din; the slave (the controller) returns dout and its state view.
interface fsm_3_mealy_ctrl_if;

    logic       din;
    logic       dout;
    logic [1:0] p_state;
    logic [1:0] n_state;

    modport master (
        output din,
        input  dout,
        input  p_state,
        input  n_state
    );

    modport slave (
        input  din,
        output dout,
        output p_state,
        output n_state
    );

endinterface : fsm_3_mealy_ctrl_if

// File: rtl/fsm_3_mealy_ctrl.sv
// Three-state Mealy controller: din steers IDLE/S0/S1, and dout pulses when din=1 in S1.
// The state register, next-state logic and output logic are kept as three separate blocks.
module fsm_3_mealy_ctrl
    import fsm_3_mealy_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    fsm_3_mealy_ctrl_if.slave  bus
);

    state_t state_q;
    state_t state_d;
    logic   dout_c;

    // NOTE: the state register uses non-blocking assignment so every reader sees the pre-edge value.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // NOTE: the default at the top of the block covers every path, so no latch can be inferred.
    always_comb begin
        state_d = IDLE;
        case (state_q)
            IDLE:    state_d = bus.din ? S1 : S0;
            S0:      state_d = bus.din ? S1 : S0;
            S1:      state_d = bus.din ? S0 : S1;
            default: state_d = IDLE;
        endcase
    end

    // dout is Mealy: it follows din within the cycle, without a register stage.
    always_comb begin
        dout_c = 1'b0;
        if (state_q == S1) begin
            dout_c = bus.din;
        end
    end

    assign bus.dout    = dout_c;
    assign bus.p_state = state_q;
    assign bus.n_state = state_d;

endmodule : fsm_3_mealy_ctrl

// File: tb/tb_fsm_3_mealy_ctrl.sv
// Self-checking bench for fsm_3_mealy_ctrl: directed scenarios then random din/reset traffic
// compared against an abstract model (0=IDLE, 1=S0, 2=S1, 3=illegal).
module tb_fsm_3_mealy_ctrl;

    logic clk = 1'b0;
    logic rst = 1'b0;

    fsm_3_mealy_ctrl_if bus_if ();

    fsm_3_mealy_ctrl dut (
        .clk (clk),
        .rst (rst),
        .bus (bus_if)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;
    int m     = 0;

    task automatic check_eq(input string tag, input logic [1:0] got, input logic [1:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %b expected %b at %0t", tag, got, exp, $time);
        end
    endtask

    // Abstract rules: IDLE picks S0/S1 from din; din=1 swaps S0<->S1 (3 - s); din=0 holds.
    function automatic int next_of(input int s, input logic d);
        if (s == 3) return 0;
        if (s == 0) return d ? 2 : 1;
        return d ? 3 - s : s;
    endfunction

    function automatic logic [1:0] enc(input int s);
        case (s)
            0:       return 2'b00;
            1:       return 2'b01;
            2:       return 2'b10;
            default: return 2'b11;
        endcase
    endfunction

    task automatic compare(input string tag);
        check_eq({tag, "/p_state"}, bus_if.p_state, enc(m));
        check_eq({tag, "/n_state"}, bus_if.n_state, enc(next_of(m, bus_if.din)));
        check_eq({tag, "/dout"}, {1'b0, bus_if.dout}, {1'b0, (m == 2) && (bus_if.din == 1'b1)});
    endtask

    task automatic apply(input logic d, input string tag);
        bus_if.din = d;
        #1;
        compare(tag);
        @(posedge clk);
        m = next_of(m, d);
        #1;
    endtask

    task automatic do_reset(input string tag);
        rst = 1'b0;
        #1;
        m = 0;
        compare(tag);
        @(negedge clk);
        rst = 1'b1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bus_if.din = 1'b0;
        #3;
        compare("reset_din0");
        bus_if.din = 1'b1;
        #1;
        compare("reset_din1");
        @(negedge clk);
        rst = 1'b1;

        // Start-up to S1 with din held high: 00,10,01,10,... and dout 0,1,0,1,...
        for (int i = 0; i < 6; i++) apply(1'b1, "startup_s1");
        check_eq("startup_s1_final", bus_if.p_state, 2'b01);

        // Start-up to S0 with din held low.
        do_reset("async_rst_s0");
        for (int i = 0; i < 4; i++) apply(1'b0, "startup_s0");
        check_eq("startup_s0_final", bus_if.p_state, 2'b01);

        // Reach S1, hold it for three cycles, then release with din=1.
        apply(1'b1, "to_s1");
        for (int i = 0; i < 3; i++) apply(1'b0, "hold_s1");
        apply(1'b1, "leave_s1");
        check_eq("leave_s1_final", bus_if.p_state, 2'b01);

        // Back into S1, then toggle din several times between edges.
        apply(1'b1, "to_s1_again");
        check_eq("in_s1", bus_if.p_state, 2'b10);
        for (int k = 0; k < 4; k++) begin
            bus_if.din = k[0];
            #1;
            compare("mealy_toggle");
        end
        bus_if.din = 1'b1;
        #1;
        compare("mealy_din1");

        // Asynchronous reset mid-cycle while sitting in S1 with din=1.
        do_reset("async_rst_s1");

        // Illegal encoding forced into the state register.
        apply(1'b1, "pre_illegal");
        force dut.state_q = fsm_3_mealy_pkg::state_t'(2'b11);
        m = 3;
        bus_if.din = 1'b1;
        #1;
        compare("illegal_din1");
        bus_if.din = 1'b0;
        #1;
        compare("illegal_din0");
        release dut.state_q;
        @(posedge clk);
        m = 0;
        #1;
        check_eq("illegal_recover", bus_if.p_state, 2'b00);

        // Random din with occasional mid-operation resets.
        for (int i = 0; i < 300; i++) begin
            if ($urandom_range(0, 19) == 0) do_reset("rand_rst");
            else apply(1'($urandom_range(0, 1)), "rand");
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule : tb_fsm_3_mealy_ctrl
